// File: rtl/framed_sequence_tx.sv
// Serial frame transmitter: 4-bit preamble then an MSB-first payload, with a stuffed '1'
// inserted wherever the last three sent bits are 101 so the marker never recurs in a frame.
module framed_sequence_tx #(
   parameter int          DATA_W   = 8,
   parameter logic [3:0]  PREAMBLE = 4'b1010
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   output logic              busy,
   output logic              out,
   output logic              out_valid,
   output logic              stuff,
   output logic              done
);

   // state | meaning
   // IDLE  | waiting for start; all outputs low
   // PRE   | preamble bit cnt_q on the line (0..3)
   // DATA  | payload or stuffed bit on the line; cnt_q = payload bits sent
   // DONE  | one-cycle done pulse, line idle, still busy
   typedef enum logic [1:0] {IDLE, PRE, DATA, DONE} state_t;

   localparam int CW = ($clog2(DATA_W + 1) < 2) ? 2 : $clog2(DATA_W + 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        hist_q, hist_d;
   logic              out_q, out_d;
   logic              valid_q, valid_d;
   logic              stuff_q, stuff_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   logic              data_step;
   logic [CW-1:0]     dcnt;
   logic              pre_bit;

   assign pre_bit = PREAMBLE[2'd2 - cnt_q[1:0]];

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      hist_d    = hist_q;
      out_d     = 1'b0;
      valid_d   = 1'b0;
      stuff_d   = 1'b0;
      done_d    = 1'b0;
      busy_d    = busy_q;
      data_step = 1'b0;
      dcnt      = cnt_q;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               data_d  = data_in;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = PRE;
               out_d   = PREAMBLE[3];
               valid_d = 1'b1;
               hist_d  = {2'b00, PREAMBLE[3]};
            end
         end
         PRE: begin
            if (cnt_q != CW'(3)) begin
               cnt_d   = cnt_q + 1'b1;
               out_d   = pre_bit;
               valid_d = 1'b1;
               hist_d  = {hist_q[1:0], pre_bit};
            end else begin
               data_step = 1'b1;
               dcnt      = '0;
            end
         end
         DATA: data_step = 1'b1;
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
            hist_d  = '0;
            data_d  = '0;
         end
      endcase

      // Stuffing is checked before every payload bit and once more after the last one.
      if (data_step) begin
         state_d = DATA;
         cnt_d   = dcnt;
         if (hist_q == 3'b101) begin
            out_d   = 1'b1;
            valid_d = 1'b1;
            stuff_d = 1'b1;
            hist_d  = {hist_q[1:0], 1'b1};
         end else if (dcnt == CW'(DATA_W)) begin
            state_d = DONE;
            done_d  = 1'b1;
         end else begin
            out_d   = data_q[DATA_W-1];
            valid_d = 1'b1;
            hist_d  = {hist_q[1:0], data_q[DATA_W-1]};
            data_d  = data_q << 1;
            cnt_d   = dcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         hist_q  <= '0;
         out_q   <= 1'b0;
         valid_q <= 1'b0;
         stuff_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         hist_q  <= hist_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         stuff_q <= stuff_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign out       = out_q;
   assign out_valid = valid_q;
   assign stuff     = stuff_q;
   assign done      = done_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_framed_sequence_tx.sv
// Bench for framed_sequence_tx: expected bits are queued at stimulus time and
// popped by a negedge monitor whenever out_valid is high.
module tb_framed_sequence_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       busy, out, out_valid, stuff, done;

   typedef struct packed {logic b; logic s; logic last;} exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   bits_seen = 0;
   bit   done_pending = 1'b0;

   always #5 clk = ~clk;

   framed_sequence_tx #(.DATA_W(8), .PREAMBLE(4'b1010)) dut (
      .clk(clk), .reset(reset), .start(start), .data_in(data_in),
      .busy(busy), .out(out), .out_valid(out_valid), .stuff(stuff), .done(done)
   );

   // scoreboard monitor
   always @(negedge clk) begin
      if (reset) begin
         if (done_pending) begin
            checks++;
            if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL done_cycle: done=%b out_valid=%b busy=%b, required 1 0 1", done, out_valid, busy);
            end
            done_pending = 1'b0;
         end else if (done !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done=%b, required 0", done);
         end
         if (out_valid === 1'b1) begin
            checks++;
            bits_seen++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_bit: out=%b stuff=%b with empty scoreboard", out, stuff);
            end else begin
               e = exp_q.pop_front();
               if (out !== e.b || stuff !== e.s) begin
                  errors++;
                  $display("FAIL bit_%0d: out=%b stuff=%b, required out=%b stuff=%b", bits_seen - 1, out, stuff, e.b, e.s);
               end
               if (e.last) done_pending = 1'b1;
            end
         end else if (out !== 1'b0 || stuff !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_line: out=%b stuff=%b, required 0 0", out, stuff);
         end
      end
   end

   function automatic void push_model(input logic [7:0] d);
      logic [2:0] h;
      logic [3:0] pre;
      h = 3'b000;
      pre = 4'b1010;
      for (int i = 3; i >= 0; i--) begin
         exp_q.push_back('{b: pre[i], s: 1'b0, last: 1'b0});
         h = {h[1:0], pre[i]};
      end
      for (int i = 7; i >= 0; i--) begin
         if (h == 3'b101) begin
            exp_q.push_back('{b: 1'b1, s: 1'b1, last: 1'b0});
            h = {h[1:0], 1'b1};
         end
         exp_q.push_back('{b: d[i], s: 1'b0, last: 1'b0});
         h = {h[1:0], d[i]};
      end
      if (h == 3'b101) exp_q.push_back('{b: 1'b1, s: 1'b1, last: 1'b0});
      exp_q[exp_q.size() - 1].last = 1'b1;
   endfunction

   function automatic void push_const(input logic [15:0] v, input logic [15:0] m, input int len);
      for (int i = 0; i < len; i++)
         exp_q.push_back('{b: v[15-i], s: m[15-i], last: (i == len - 1)});
   endfunction

   task automatic send(input logic [7:0] d);
      @(posedge clk); #1;
      start = 1'b1;
      data_in = d;
      @(posedge clk); #1;
      start = 1'b0;
      data_in = 8'($urandom);
   endtask

   task automatic wait_frame(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (exp_q.size() == 0 && !done_pending && busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit ok;
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({busy, out, out_valid, stuff, done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: %b, required 00000", {busy, out, out_valid, stuff, done});
      end
      repeat (3) @(negedge clk);
      bits_seen = 0;
      push_const(16'b1010_0000_0000_0000, 16'h0000, 12);
      reset = 1'b1;
      start = 1'b1;
      data_in = 8'h00;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL first_start: out_valid=%b busy=%b, required 1 1", out_valid, busy);
      end
      wait_frame(ok);
      checks++;
      if (!ok || bits_seen != 12) begin
         errors++;
         $display("FAIL first_frame: ok=%0d bits=%0d, required 1 12", ok, bits_seen);
      end
   endtask

   task automatic test_vectors();
      logic [7:0]  d[4]  = '{8'h00, 8'hFF, 8'hAA, 8'h05};
      logic [15:0] v[4]  = '{16'b1010_0000_0000_0000, 16'b1010_1111_1111_1000,
                             16'b1010_1101_1011_0110, 16'b1010_0000_0101_1000};
      logic [15:0] m[4]  = '{16'h0000, 16'b0000_0100_0000_0000,
                             16'b0000_0100_1001_0010, 16'b0000_0000_0000_1000};
      int          len[4] = '{12, 13, 16, 13};
      bit ok;
      for (int k = 0; k < 4; k++) begin
         bits_seen = 0;
         push_const(v[k], m[k], len[k]);
         send(d[k]);
         wait_frame(ok);
         checks++;
         if (!ok || bits_seen != len[k]) begin
            errors++;
            $display("FAIL vector_%h: ok=%0d bits=%0d, required 1 %0d", d[k], ok, bits_seen, len[k]);
         end
      end
   endtask

   task automatic test_random();
      bit ok;
      int n;
      logic [7:0] d;
      for (int k = 0; k < 8; k++) begin
         d = 8'($urandom);
         bits_seen = 0;
         push_model(d);
         n = exp_q.size();
         send(d);
         wait_frame(ok);
         checks++;
         if (!ok || bits_seen != n) begin
            errors++;
            $display("FAIL random_%h: ok=%0d bits=%0d, required 1 %0d", d, ok, bits_seen, n);
         end
      end
   endtask

   task automatic test_start_ignored();
      bit ok;
      bits_seen = 0;
      push_model(8'h3C);
      send(8'h3C);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         start = 1'b1;
         data_in = 8'hFF;
         @(posedge clk); #1;
         start = 1'b0;
      end
      wait_frame(ok);
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (!ok || bits_seen != 12 || busy !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL start_ignored: ok=%0d bits=%0d busy=%b, required 1 12 0", ok, bits_seen, busy);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      bit seen;
      seen = 1'b0;
      push_model(8'hA5);
      send(8'hA5);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL b2b_done: done never seen, required a pulse");
      end
      bits_seen = 0;
      push_model(8'h0F);
      @(posedge clk); #1;
      start = 1'b1;
      data_in = 8'h0F;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out !== 1'b1) begin
         errors++;
         $display("FAIL b2b_preamble: out_valid=%b out=%b, required 1 1", out_valid, out);
      end
      wait_frame(ok);
      checks++;
      if (!ok || bits_seen != 12) begin
         errors++;
         $display("FAIL b2b_frame: ok=%0d bits=%0d, required 1 12", ok, bits_seen);
      end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      bits_seen = 0;
      push_model(8'hC3);
      send(8'hC3);
      for (int i = 0; i < 20 && bits_seen < 8; i++) begin
         @(negedge clk); #1;
      end
      reset = 1'b0;
      exp_q.delete();
      done_pending = 1'b0;
      #1;
      checks++;
      if ({busy, out, out_valid, stuff, done} !== 5'b0 || bits_seen != 8) begin
         errors++;
         $display("FAIL mid_reset: outs=%b bits=%0d, required 00000 8", {busy, out, out_valid, stuff, done}, bits_seen);
      end
      repeat (2) @(negedge clk);
      bits_seen = 0;
      push_const(16'b1010_0000_0000_0000, 16'h0000, 12);
      reset = 1'b1;
      start = 1'b1;
      data_in = 8'h00;
      @(posedge clk); #1;
      start = 1'b0;
      wait_frame(ok);
      checks++;
      if (!ok || bits_seen != 12) begin
         errors++;
         $display("FAIL post_reset_frame: ok=%0d bits=%0d, required 1 12", ok, bits_seen);
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_random();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_frame();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
